// File: rtl/bitwise_accum.sv
// Bitwise operator unit: single-beat word ops (a op b) or multi-beat accumulation of a
// under a latched op, with a saturating beat counter and a valid/ready result hold.
module bitwise_accum #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         op,
    input  logic               mode,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_sat
);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_t;

    localparam logic [COUNT_W-1:0] CountMax = '1;
    localparam logic [COUNT_W-1:0] CountOne = COUNT_W'(1);

    state_t             r_state, w_state_next;
    logic [WIDTH-1:0]   r_acc, w_acc_next;
    logic [WIDTH-1:0]   r_y, w_y_next;
    logic [1:0]         r_op, w_op_next;
    logic [COUNT_W-1:0] r_count, w_count_next;
    logic               r_sat, w_sat_next;
    logic               w_accept;
    logic [WIDTH-1:0]   w_acc_upd;

    function automatic logic [WIDTH-1:0] f_apply(input logic [1:0] f_op,
                                                 input logic [WIDTH-1:0] f_x,
                                                 input logic [WIDTH-1:0] f_z);
        logic [WIDTH-1:0] res;
        case (f_op)
            2'b00:   res = f_x & f_z;
            2'b01:   res = f_x | f_z;
            2'b10:   res = f_x ^ f_z;
            default: res = ~(f_x | f_z);
        endcase
        return res;
    endfunction

    assign in_ready  = (r_state != StHold);
    assign out_valid = (r_state == StHold);
    assign w_accept  = in_valid & in_ready;
    assign w_acc_upd = f_apply(r_op, r_acc, a);
    assign y         = r_y;
    assign out_count = r_count;
    assign out_sat   = r_sat;

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_y_next     = r_y;
        w_op_next    = r_op;
        w_count_next = r_count;
        w_sat_next   = r_sat;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_count_next = CountOne;
                    w_sat_next   = 1'b0;
                    if (!mode) begin
                        w_y_next     = f_apply(op, a, b);
                        w_state_next = StHold;
                    end else begin
                        w_acc_next   = a;
                        w_op_next    = op;
                        w_y_next     = a;
                        w_state_next = in_last ? StHold : StAccum;
                    end
                end
            end
            StAccum: begin
                // b, op and mode are ignored mid-burst; the op latched on the first beat rules.
                if (w_accept) begin
                    w_acc_next = w_acc_upd;
                    if (r_count == CountMax) begin
                        w_sat_next = 1'b1;
                    end else begin
                        w_count_next = r_count + CountOne;
                    end
                    if (in_last) begin
                        w_y_next     = w_acc_upd;
                        w_state_next = StHold;
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_y     <= '0;
            r_op    <= 2'b00;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_y     <= w_y_next;
            r_op    <= w_op_next;
            r_count <= w_count_next;
            r_sat   <= w_sat_next;
        end
    end

endmodule

// File: tb/tb_bitwise_accum.sv
// Self-checking bench for bitwise_accum: two instances (COUNT_W=8 and COUNT_W=2) share
// stimulus; results are checked against vectors and a burst-level reference model.
module tb_bitwise_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] a, b;
    logic [1:0]  op;
    logic        mode, in_last, out_ready;
    logic        in_ready0, in_ready1, out_valid0, out_valid1, sat0, sat1;
    logic [31:0] y0, y1;
    logic [7:0]  cnt0;
    logic [1:0]  cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bitwise_accum #(.WIDTH(32), .COUNT_W(8)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .op(op), .mode(mode), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .y(y0),
        .out_count(cnt0), .out_sat(sat0)
    );

    bitwise_accum #(.WIDTH(32), .COUNT_W(2)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .op(op), .mode(mode), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready), .y(y1),
        .out_count(cnt1), .out_sat(sat1)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] y;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_op(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] z);
        if (o == 2'd0) return x & z;
        if (o == 2'd1) return x | z;
        if (o == 2'd2) return x ^ z;
        return ~(x | z);
    endfunction

    task automatic send_beat(input logic [31:0] av, input logic [31:0] bv, input logic [1:0] ov,
                             input logic mv, input logic lv);
        @(negedge clk);
        check("in_ready0_before_beat", in_ready0, 1'b1);
        check("in_ready1_before_beat", in_ready1, 1'b1);
        a = av; b = bv; op = ov; mode = mv; in_last = lv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom); mode = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    // Called just after the accepting edge of the final beat of a transaction.
    task automatic collect(input logic [31:0] exp_y, input int n, input int hold);
        logic [7:0] ec0;
        logic [1:0] ec1;
        ec0 = (n > 255) ? 8'd255 : 8'(n);
        ec1 = (n > 3) ? 2'd3 : 2'(n);
        check("out_valid0", out_valid0, 1'b1);
        check("out_valid1", out_valid1, 1'b1);
        check("in_ready0_hold", in_ready0, 1'b0);
        check("y0", y0, exp_y);
        check("y1", y1, exp_y);
        check("count0", cnt0, ec0);
        check("sat0", sat0, n > 255);
        check("count1", cnt1, ec1);
        check("sat1", sat1, n > 3);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a = $urandom; b = $urandom; mode = 1'b0; in_last = 1'b1;
            @(posedge clk);
            #1;
            check("y0_stable", y0, exp_y);
            check("count0_stable", cnt0, ec0);
            check("out_valid0_stable", out_valid0, 1'b1);
            check("in_ready0_blocked", in_ready0, 1'b0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid0_released", out_valid0, 1'b0);
        check("in_ready0_released", in_ready0, 1'b1);
    endtask

    task automatic run_random();
        logic [31:0] q[$];
        logic [31:0] acc;
        logic [1:0]  o;
        int          len;
        o = 2'($urandom);
        if ($urandom_range(0, 2) == 0) begin
            logic [31:0] av, bv;
            av = $urandom; bv = $urandom;
            send_beat(av, bv, o, 1'b0, 1'($urandom));
            collect(model_op(o, av, bv), 1, $urandom_range(0, 2));
        end else begin
            len = $urandom_range(1, 8);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back($urandom);
            for (int i = 0; i < len; i++) begin
                if (i > 0 && $urandom_range(0, 2) == 0) idle_cycle();
                send_beat(q[i], $urandom, (i == 0) ? o : 2'($urandom),
                          (i == 0) ? 1'b1 : 1'($urandom), i == len - 1);
            end
            acc = q[0];
            foreach (q[i]) if (i > 0) acc = model_op(o, acc, q[i]);
            collect(acc, len, $urandom_range(0, 2));
        end
    endtask

    vec_t vecs[4];

    initial begin
        logic [31:0] acc;
        logic [31:0] av;
        vecs[0] = '{32'h0F0F0000, 32'h3C222A81, 2'b00, 32'h0C020000};
        vecs[1] = '{32'h0F0F0000, 32'h3C222A81, 2'b01, 32'h3F2F2A81};
        vecs[2] = '{32'h0F0F0000, 32'h3C222A81, 2'b10, 32'h332D2A81};
        vecs[3] = '{32'h0F0F0000, 32'h3C222A81, 2'b11, 32'hC0D0D57E};

        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
        mode = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready0, 1'b1);
        check("reset_out_valid", out_valid0, 1'b0);
        check("reset_y", y0, 32'h0);
        check("reset_count", cnt0, 8'h0);
        check("reset_sat", sat0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            send_beat(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, 1'b0);
            collect(vecs[i].y, 1, 0);
        end

        // XOR burst, then backpressure for 3 cycles
        send_beat(32'h000000FF, 32'h0, 2'b10, 1'b1, 1'b0);
        send_beat(32'h0000FF00, 32'hFFFFFFFF, 2'b00, 1'b0, 1'b0);
        send_beat(32'h000000F0, 32'h0, 2'b01, 1'b1, 1'b1);
        collect(32'h0000FF0F, 3, 3);

        // OR over 5 beats: the COUNT_W=2 instance saturates
        for (int i = 0; i < 5; i++) send_beat(32'(1 << i), 32'h0, 2'b01, 1'b1, i == 4);
        collect(32'h0000001F, 5, 0);

        // Single-beat NOR burst passes a through unchanged
        send_beat(32'hDEADBEEF, 32'h12345678, 2'b11, 1'b1, 1'b1);
        collect(32'hDEADBEEF, 1, 1);

        // Reset mid-burst discards everything
        send_beat(32'h11111111, 32'h0, 2'b01, 1'b1, 1'b0);
        send_beat(32'h22222222, 32'h0, 2'b01, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midburst_rst_out_valid", out_valid0, 1'b0);
        check("midburst_rst_in_ready", in_ready0, 1'b1);
        check("midburst_rst_y", y0, 32'h0);
        check("midburst_rst_count", cnt0, 8'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            check("post_rst_out_valid", out_valid0, 1'b0);
        end
        send_beat(32'hF0F0F0F0, 32'hFF00FF00, 2'b10, 1'b0, 1'b0);
        collect(32'h0FF00FF0, 1, 0);

        // Long XOR burst saturating the 8-bit counter
        acc = '0;
        for (int i = 0; i < 260; i++) begin
            av = $urandom;
            acc = (i == 0) ? av : (acc ^ av);
            send_beat(av, $urandom, (i == 0) ? 2'b10 : 2'($urandom), 1'b1, i == 259);
        end
        collect(acc, 260, 0);

        for (int t = 0; t < 40; t++) run_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitwise_accum.md
BITWISE_ACCUM -- requirements
Module: bitwise_accum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter COUNT_W, default 8, giving the width of the beat counter.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be an asynchronous active-high reset.
REQ-005 Port in_valid, input, 1 bit, SHALL mark a, b, op, mode and in_last as valid.
REQ-006 Port in_ready, output, 1 bit, SHALL mark that the block accepts a beat this cycle.
REQ-007 Port a, input, WIDTH bits, SHALL be operand A.
REQ-008 Port b, input, WIDTH bits, SHALL be operand B, used in word mode only.
REQ-009 Port op, input, 2 bits, SHALL select 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-010 Port mode, input, 1 bit, SHALL select 0 word mode and 1 accumulate mode.
REQ-011 Port in_last, input, 1 bit, SHALL mark the final beat of an accumulate burst.
REQ-012 Port out_valid, output, 1 bit, SHALL mark y, out_count and out_sat as valid.
REQ-013 Port out_ready, input, 1 bit, SHALL mark that the consumer takes the result.
REQ-014 Port y, output, WIDTH bits, SHALL carry the result.
REQ-015 Port out_count, output, COUNT_W bits, SHALL carry the number of beats consumed.
REQ-016 Port out_sat, output, 1 bit, SHALL flag that out_count saturated.

Function
REQ-017 A beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-018 The FSM SHALL have three states: IDLE, ACCUM and HOLD; in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-019 In IDLE, a beat accepted with mode=0 SHALL load y = a op b and out_count = 1, then go to HOLD.
REQ-020 In IDLE, a beat accepted with mode=1 SHALL load acc = a, latch op and set count = 1; it SHALL then go to HOLD if in_last=1 and to ACCUM otherwise.
REQ-021 In ACCUM, each accepted beat SHALL update acc = acc op_latched a, ignoring b, op and mode, and SHALL increment count.
REQ-022 An accepted ACCUM beat with in_last=1 SHALL go to HOLD with y = the updated acc.
REQ-023 NOR accumulation SHALL compute acc = ~(acc | a) per beat.
REQ-024 out_valid SHALL be 1 exactly while in HOLD; result latency SHALL be 1 cycle after the accepting edge.
REQ-025 In HOLD, y, out_count and out_sat SHALL stay stable until out_valid and out_ready are both 1 on an edge; that edge SHALL return the FSM to IDLE.
REQ-026 Sustained throughput SHALL therefore be one result per two cycles minimum.
REQ-027 count SHALL saturate at 2^COUNT_W-1; further beats SHALL set the sticky sat flag and leave count unchanged.
REQ-028 count and sat SHALL clear on every IDLE accept.
REQ-029 in_valid=0 in ACCUM SHALL hold acc and count unchanged indefinitely.

Reset
REQ-030 Asserting reset SHALL immediately force state IDLE and clear y, acc, out_count, out_sat, out_valid and the latched op to 0.
REQ-031 A reset asserted mid-burst or in HOLD SHALL discard the partial or held result; no output beat SHALL be produced for it.
REQ-032 in_ready SHALL be 1 while reset is asserted and after release (IDLE).

Verification
REQ-033 Word mode, WIDTH=32, a=0x0F0F0000, b=0x3C222A81, op=00/01/10/11 -> y=0x0C020000/0x3F2F2A81/0x332D2A81/0xC0D0D57E, out_count=1, out_valid one cycle after accept.
REQ-034 Accumulate XOR with beats a=0x000000FF, 0x0000FF00, 0x000000F0 (last) -> y=0x0000FF0F, out_count=3, out_sat=0.
REQ-035 Backpressure: hold out_ready=0 for 3 cycles in HOLD -> y stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-036 COUNT_W=2, accumulate OR over 5 beats of 0x1,0x2,0x4,0x8,0x10 -> y=0x1F, out_count=3, out_sat=1.
REQ-037 Reset asserted after 2 beats of a burst -> out_valid stays 0; a following word-mode beat yields the correct result with out_count=1.
REQ-038 Single-beat burst with mode=1, in_last=1, a=0xDEADBEEF, op=11 -> y=0xDEADBEEF, out_count=1.
